// File: rtl/fifo_tx_packetizer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_tx_packetizer
//
// Write-side traffic source for the asynchronous FIFO (wr_clk domain). On an
// accepted start it emits one framed packet into the FIFO write port:
//   SYNC, length, payload (base, base+1, ...), checksum
// where base is the low WIDTH bits of pkt_count at acceptance. The checksum is
// the modulo-2^WIDTH sum of the length word and all payload words. A word moves
// only on cycles where the FIFO is not full, so back-pressure stalls the packet
// without losing or repeating words.
//
// Ports:
//   wr_clk     write-domain clock, rising edge
//   reset      asynchronous, active-high reset
//   start      packet request, sampled only while idle
//   pkt_len    payload word count, latched at acceptance
//   wr_full    FIFO full flag
//   wr_en      FIFO write strobe (one word per high cycle)
//   wr_data    FIFO write data
//   busy       high from the cycle after acceptance until idle again
//   done       one-cycle pulse after the checksum word has been written
//   pkt_count  packets completed since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo_tx_packetizer #(
    parameter int         WIDTH = 8,
    parameter int         LEN_W = 8,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic             wr_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             wr_full,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pkt_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [WIDTH-1:0] SYNC_W  = WIDTH'(SYNC);

    logic [2:0]       state_q,     state_d;
    logic [LEN_W-1:0] len_q,       len_d;
    logic [LEN_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] base_q,      base_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic emit_state;

    // The outgoing word depends only on registered state, so it stays put
    // for as long as the FIFO holds off the write.
    always_comb begin
        wr_data = '0;
        case (state_q)
            S_HDR:   wr_data = SYNC_W;
            S_LEN:   wr_data = WIDTH'(len_q);
            S_PAY:   wr_data = base_q + WIDTH'(idx_q);
            S_CSUM:  wr_data = sum_q;
            default: wr_data = '0;
        endcase
    end

    always_comb begin
        emit_state = (state_q == S_HDR) || (state_q == S_LEN) ||
                     (state_q == S_PAY) || (state_q == S_CSUM);
        // Combinational from wr_full: a full FIFO blocks the write this cycle.
        wr_en = emit_state && !wr_full;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        base_d      = base_q;
        sum_d       = sum_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = pkt_len;
                    base_d  = WIDTH'(pkt_count_q);
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (wr_en) state_d = S_LEN;
            end
            S_LEN: begin
                if (wr_en) begin
                    // Length word is part of the checksum; the header is not.
                    sum_d   = sum_q + wr_data;
                    state_d = (len_q != '0) ? S_PAY : S_CSUM;
                end
            end
            S_PAY: begin
                if (wr_en) begin
                    sum_d = sum_q + wr_data;
                    idx_d = idx_q + LEN_ONE;
                    if (idx_q == len_q - LEN_ONE) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (wr_en) state_d = S_DONE;
            end
            S_DONE: begin
                pkt_count_d = pkt_count_q + 16'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            sum_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            sum_q       <= sum_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_tx_packetizer.sv
`timescale 1ns/1ps
module tb_fifo_tx_packetizer;

    localparam int DEPTH = 8;

    logic        wr_clk;
    logic        rd_clk;
    logic        reset;
    logic        start;
    logic [7:0]  pkt_len;
    logic        wr_full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    logic        fifo_mode;
    logic        full_man;
    logic        full_fifo;

    assign wr_full = fifo_mode ? full_fifo : full_man;

    fifo_tx_packetizer #(.WIDTH(8), .LEN_W(8), .SYNC(8'hA5)) dut (
        .wr_clk    (wr_clk),
        .reset     (reset),
        .start     (start),
        .pkt_len   (pkt_len),
        .wr_full   (wr_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .pkt_count (pkt_count)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    initial begin
        rd_clk = 1'b0;
        forever #18.5 rd_clk = ~rd_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    int         wr_cnt = 0;
    int         cyc_n  = 0;
    int         hdr_cyc[$];
    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];

    always @(posedge wr_clk) cyc_n++;

    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (wr_data == 8'hA5) hdr_cyc.push_back(cyc_n);
            if (fifo_mode) begin
                chk("e2e_no_overflow", 32'(fifo.size() < DEPTH), 32'd1);
                fifo.push_back(wr_data);
            end
        end
    end

    always @(posedge wr_clk) begin
        #1;
        full_fifo = (fifo.size() >= DEPTH);
    end

    always @(posedge rd_clk) begin
        logic [7:0] w;
        if (fifo.size() > 0 && $urandom_range(0, 3) != 0) begin
            w = fifo.pop_front();
            if (exp_q.size() == 0) chk("e2e_unexpected_word", 32'd1, 32'd0);
            else chk("e2e_word", 32'(w), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- table-driven packets ----------------
    typedef struct {
        logic [7:0]       len;
        int               stall_idx;   // word index held off by wr_full (-1: none)
        int               stall_n;
        int               n;
        logic [0:9][7:0]  w;
        logic [15:0]      cnt_after;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input string tag);
        int got;
        int stall_left;
        int cyc;
        @(posedge wr_clk); #1;
        start = 1'b1; pkt_len = v.len;
        @(posedge wr_clk); #1;
        start = 1'b0; pkt_len = ~v.len;   // must not affect the packet in flight
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        got = 0; stall_left = v.stall_n; cyc = 0;
        while (got < v.n && cyc < 100) begin
            full_man = (got == v.stall_idx) && (stall_left > 0);
            @(negedge wr_clk);
            if (full_man) begin
                chk($sformatf("%s_stall_wr_en_w%0d", tag, got), 32'(wr_en), 32'd0);
                chk($sformatf("%s_stall_data_w%0d", tag, got), 32'(wr_data), 32'(v.w[got]));
                stall_left--;
            end else begin
                chk($sformatf("%s_wr_en_w%0d", tag, got), 32'(wr_en), 32'd1);
                chk($sformatf("%s_data_w%0d", tag, got), 32'(wr_data), 32'(v.w[got]));
                got++;
            end
            @(posedge wr_clk); #1;
            cyc++;
        end
        full_man = 1'b0;
        if (cyc >= 100) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge wr_clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_no_wr"}, 32'(wr_en), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(v.cnt_after));
        @(posedge wr_clk); #1;
    endtask

    task automatic send(input logic [7:0] len);
        int k;
        @(posedge wr_clk); #1;
        start = 1'b1; pkt_len = len;
        @(posedge wr_clk); #1;
        start = 1'b0; pkt_len = 8'($urandom);
        k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(posedge wr_clk); #1;
            k++;
        end
        if (k >= 2000) chk("send_timeout", 32'd0, 32'd1);
        @(posedge wr_clk); #1;
    endtask

    initial begin
        vec_t       wv;
        int         w0;
        int         k;
        logic [15:0] model_count;

        reset = 1'b1; start = 1'b0; pkt_len = 8'd0;
        full_man = 1'b0; fifo_mode = 1'b0;

        vecs[0] = '{8'd4, -1, 0, 7,
                    {8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 24'h0}, 16'd1};
        vecs[1] = '{8'd3, 3, 5, 6,
                    {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09, 32'h0}, 16'd2};
        vecs[2] = '{8'd0, -1, 0, 3,
                    {8'hA5, 8'h00, 8'h00, 56'h0}, 16'd3};
        vecs[3] = '{8'd5, 0, 2, 8,
                    {8'hA5, 8'h05, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1E, 16'h0}, 16'd4};

        // ---- reset state ----
        #12;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        @(posedge wr_clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---- start pulsed while busy is ignored ----
        w0 = wr_cnt;
        @(posedge wr_clk); #1; start = 1'b1; pkt_len = 8'd2;
        @(posedge wr_clk); #1; start = 1'b0;
        @(posedge wr_clk); #1;
        @(posedge wr_clk); #1; start = 1'b1;
        @(posedge wr_clk); #1; start = 1'b0;
        repeat (20) @(posedge wr_clk);
        #1;
        chk("busy_start_writes", 32'(wr_cnt - w0), 32'd5);
        chk("busy_start_count", 32'(pkt_count), 32'd5);

        // ---- start held: back-to-back packets, len+5 cycles apart ----
        hdr_cyc.delete();
        start = 1'b1; pkt_len = 8'd1;
        k = 0;
        while (hdr_cyc.size() < 3 && k < 200) begin
            @(negedge wr_clk);
            k++;
        end
        start = 1'b0;
        if (hdr_cyc.size() < 3) chk("b2b_timeout", 32'd0, 32'd1);
        else begin
            chk("b2b_gap0", 32'(hdr_cyc[1] - hdr_cyc[0]), 32'd6);
            chk("b2b_gap1", 32'(hdr_cyc[2] - hdr_cyc[1]), 32'd6);
        end
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(posedge wr_clk); #1;
            k++;
        end
        chk("b2b_count", 32'(pkt_count), 32'd8);

        // ---- reset during payload abandons the packet ----
        @(posedge wr_clk); #1; start = 1'b1; pkt_len = 8'd6;
        @(posedge wr_clk); #1; start = 1'b0;
        repeat (3) @(posedge wr_clk);   // HDR, LEN, PAY0 written; now in PAY
        #3;
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(pkt_count), 32'd0);
        @(posedge wr_clk); #1;
        reset = 1'b0;
        w0 = wr_cnt;
        repeat (10) @(posedge wr_clk);
        #1;
        chk("post_rst_no_writes", 32'(wr_cnt - w0), 32'd0);
        chk("post_rst_count", 32'(pkt_count), 32'd0);

        // ---- advance pkt_count to 00FE with empty packets, then byte wrap ----
        for (int i = 0; i < 254; i++) send(8'd0);
        chk("pre_wrap_count", 32'(pkt_count), 32'h00FE);
        wv = '{8'd3, -1, 0, 6,
               {8'hA5, 8'h03, 8'hFE, 8'hFF, 8'h00, 8'h00, 32'h0}, 16'h00FF};
        run_vec(wv, "wrap");

        // ---- end-to-end through a modelled FIFO with a slower reader ----
        model_count = pkt_count;
        fifo_mode = 1'b1;
        for (int p = 0; p < 20; p++) begin
            logic [7:0] L;
            logic [7:0] base;
            logic [7:0] s;
            logic [7:0] v;
            L = 8'($urandom_range(0, 12));
            base = model_count[7:0];
            exp_q.push_back(8'hA5);
            exp_q.push_back(L);
            s = L;
            for (int i = 0; i < int'(L); i++) begin
                v = base + 8'(i);
                exp_q.push_back(v);
                s = s + v;
            end
            exp_q.push_back(s);
            model_count = model_count + 16'd1;
            repeat ($urandom_range(0, 3)) @(posedge wr_clk);
            send(L);
        end
        k = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && k < 5000) begin
            @(posedge wr_clk);
            k++;
        end
        #1;
        chk("e2e_all_read", 32'(exp_q.size()), 32'd0);
        chk("e2e_pkt_count", 32'(pkt_count), 32'(model_count));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
